// File: rtl/hdmi_text_axi_slave.sv
// AXI4-Lite slave for the HDMI text controller. Bus writes and reads are
// turned into byte-masked accesses on a single-port VRAM and an 8-entry
// palette register bank that feeds the text-drawing logic.
//
// Handshake rule on every channel: a transfer happens on the rising edge of
// axi_aclk where both valid and ready are 1. A valid, once raised, is held
// with its payload until that edge. Ready never depends on valid.
module hdmi_text_axi_slave #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int VRAM_WORDS       = 1200,
    parameter int PAL_BASE         = 2048
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
    input  logic [2:0]                      axi_awprot,
    input  logic                            axi_awvalid,
    output logic                            axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]     axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
    input  logic                            axi_wvalid,
    output logic                            axi_wready,
    output logic [1:0]                      axi_bresp,
    output logic                            axi_bvalid,
    input  logic                            axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     axi_araddr,
    input  logic [2:0]                      axi_arprot,
    input  logic                            axi_arvalid,
    output logic                            axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]     axi_rdata,
    output logic [1:0]                      axi_rresp,
    output logic                            axi_rvalid,
    input  logic                            axi_rready,
    output logic                            vram_en,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   vram_we,
    output logic [10:0]                     vram_addr,
    output logic [C_AXI_DATA_WIDTH-1:0]     vram_wdata,
    input  logic [C_AXI_DATA_WIDTH-1:0]     vram_rdata,
    output logic [8*C_AXI_DATA_WIDTH-1:0]   pal_out,
    output logic [1:0]                      w_state_dbg,
    output logic [1:0]                      r_state_dbg
);

    localparam int DW     = C_AXI_DATA_WIDTH;
    localparam int SW     = DW / 8;
    localparam int WORD_W = C_AXI_ADDR_WIDTH - 2;

    localparam logic [WORD_W-1:0] VRAM_LIM = WORD_W'(VRAM_WORDS);
    localparam logic [WORD_W-1:0] PAL_LO   = WORD_W'(PAL_BASE);
    localparam logic [WORD_W-1:0] PAL_HI   = WORD_W'(PAL_BASE + 8);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_CAPT  = 2'd2,
        R_DATA  = 2'd3
    } r_state_t;

    w_state_t           w_state, w_state_d;
    r_state_t           r_state, r_state_d;

    // Held low for the first cycle after reset so every ready is 0 in reset.
    logic               active;

    logic               aw_done, w_done;
    logic [WORD_W-1:0]  aw_word;
    logic [DW-1:0]      wdata_q;
    logic [SW-1:0]      wstrb_q;
    logic [1:0]         bresp_q;

    logic [WORD_W-1:0]  ar_word;
    logic [DW-1:0]      rdata_q;
    logic [1:0]         rresp_q;
    logic               rvalid_q;

    logic [DW-1:0]      pal [8];

    logic               aw_hs, w_hs, ar_hs;
    logic               wr_vram, wr_pal, rd_vram, rd_pal;
    logic [2:0]         wr_pal_idx, rd_pal_idx;
    logic               rd_stall;

    // Address low bits and protection attributes carry no meaning here.
    logic               unused_ok;
    assign unused_ok = &{1'b0, axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

    assign wr_vram    = (aw_word < VRAM_LIM);
    assign wr_pal     = (aw_word >= PAL_LO) && (aw_word < PAL_HI);
    assign rd_vram    = (ar_word < VRAM_LIM);
    assign rd_pal     = (ar_word >= PAL_LO) && (ar_word < PAL_HI);
    assign wr_pal_idx = 3'(aw_word - PAL_LO);
    assign rd_pal_idx = 3'(ar_word - PAL_LO);

    assign axi_awready = active && (w_state == W_IDLE) && !aw_done;
    assign axi_wready  = active && (w_state == W_IDLE) && !w_done;
    assign axi_arready = active && (r_state == R_IDLE);
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign ar_hs       = axi_arvalid && axi_arready;

    assign axi_bvalid  = (w_state == W_RESP);
    assign axi_bresp   = bresp_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

    // The write owns the VRAM port during W_EXEC; a VRAM read waits a cycle.
    assign rd_stall = rd_vram && (w_state == W_EXEC);

    // State registers for both channel FSMs.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_d;
            r_state <= r_state_d;
        end
    end

    // Write FSM: wait for both AW and W, execute for one cycle, hold the response.
    always_comb begin
        w_state_d = w_state;
        case (w_state)
            W_IDLE: if ((aw_done || aw_hs) && (w_done || w_hs)) w_state_d = W_EXEC;
            W_EXEC: w_state_d = W_RESP;
            W_RESP: if (axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: issue (possibly stalled), capture, then hold the data beat.
    always_comb begin
        r_state_d = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_d = R_ISSUE;
            R_ISSUE: if (!rd_stall) r_state_d = R_CAPT;
            R_CAPT:  r_state_d = R_DATA;
            R_DATA:  if (rvalid_q && axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // VRAM port mux: the executing write first, otherwise an unstalled read issue.
    always_comb begin
        vram_en    = 1'b0;
        vram_we    = '0;
        vram_addr  = '0;
        vram_wdata = '0;
        if ((w_state == W_EXEC) && wr_vram) begin
            vram_en    = 1'b1;
            vram_we    = wstrb_q;
            vram_addr  = aw_word[10:0];
            vram_wdata = wdata_q;
        end else if ((r_state == R_ISSUE) && rd_vram) begin
            vram_en    = 1'b1;
            vram_addr  = ar_word[10:0];
        end
    end

    // Flatten the palette bank onto the wide output bus.
    always_comb begin
        pal_out = '0;
        for (int i = 0; i < 8; i++) pal_out[DW*i +: DW] = pal[i];
    end

    // Write channel datapath: latch AW/W independently, commit palette bytes, form bresp.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            active  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            aw_word <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_OKAY;
            for (int i = 0; i < 8; i++) pal[i] <= '0;
        end else begin
            active <= 1'b1;
            if (aw_hs) begin
                aw_done <= 1'b1;
                aw_word <= axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_done  <= 1'b1;
                wdata_q <= axi_wdata;
                wstrb_q <= axi_wstrb;
            end
            if (w_state == W_EXEC) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                bresp_q <= (wr_vram || wr_pal) ? RESP_OKAY : RESP_SLVERR;
                if (wr_pal) begin
                    for (int b = 0; b < SW; b++) begin
                        if (wstrb_q[b]) pal[wr_pal_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read channel datapath: latch AR, capture the source in R_CAPT, run rvalid in R_DATA.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ar_word  <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
        end else begin
            if (ar_hs) ar_word <= axi_araddr[C_AXI_ADDR_WIDTH-1:2];
            if (r_state == R_CAPT) begin
                if (rd_vram) begin
                    rdata_q <= vram_rdata;
                    rresp_q <= RESP_OKAY;
                end else if (rd_pal) begin
                    rdata_q <= pal[rd_pal_idx];
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end
            end
            if (r_state == R_DATA) begin
                if (!rvalid_q) rvalid_q <= 1'b1;
                else if (axi_rready) rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_text_axi_slave.sv
// Bench for hdmi_text_axi_slave: a behavioural single-port VRAM, AXI driver
// tasks, a table of directed write/read vectors and hand-written sequences
// for ordering, back-pressure, port collision and mid-write reset.
module tb_hdmi_text_axi_slave;

    logic         clk = 1'b0;
    logic         rstn;
    logic [15:0]  awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [15:0]  araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic         vram_en;
    logic [3:0]   vram_we;
    logic [10:0]  vram_addr;
    logic [31:0]  vram_wdata;
    logic [31:0]  vram_rdata = '0;
    logic [255:0] pal_out;
    logic [1:0]   w_state_dbg;
    logic [1:0]   r_state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Clock generation.
    always #5 clk = ~clk;

    hdmi_text_axi_slave dut (
        .axi_aclk    (clk),
        .axi_aresetn (rstn),
        .axi_awaddr  (awaddr),
        .axi_awprot  (awprot),
        .axi_awvalid (awvalid),
        .axi_awready (awready),
        .axi_wdata   (wdata),
        .axi_wstrb   (wstrb),
        .axi_wvalid  (wvalid),
        .axi_wready  (wready),
        .axi_bresp   (bresp),
        .axi_bvalid  (bvalid),
        .axi_bready  (bready),
        .axi_araddr  (araddr),
        .axi_arprot  (arprot),
        .axi_arvalid (arvalid),
        .axi_arready (arready),
        .axi_rdata   (rdata),
        .axi_rresp   (rresp),
        .axi_rvalid  (rvalid),
        .axi_rready  (rready),
        .vram_en     (vram_en),
        .vram_we     (vram_we),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_rdata  (vram_rdata),
        .pal_out     (pal_out),
        .w_state_dbg (w_state_dbg),
        .r_state_dbg (r_state_dbg)
    );

    // Behavioural VRAM: byte-masked write, registered read, commit tracking.
    logic [31:0] vmem [0:2047];
    int          commit_cnt = 0;
    logic [10:0] last_waddr = '0;
    logic [3:0]  last_we = '0;

    always @(posedge clk) begin
        if (vram_en) begin
            if (vram_we != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    if (vram_we[b]) vmem[vram_addr][8*b +: 8] <= vram_wdata[8*b +: 8];
                end
                commit_cnt <= commit_cnt + 1;
                last_waddr <= vram_addr;
                last_we    <= vram_we;
            end else begin
                vram_rdata <= vmem[vram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Full write transaction. AW and W are offered after their own delays;
    // bready is held low for 'hold' cycles once bvalid is seen.
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int hold,
                             output logic [1:0] resp, output int lat);
        int cyc;
        bit aw_pend, w_pend, aw_fire, w_fire, early, unstable;
        cyc = 0; aw_pend = 1; w_pend = 1; early = 0; unstable = 0;
        @(negedge clk);
        while ((aw_pend || w_pend) && cyc < 100) begin
            if (aw_pend && cyc >= aw_dly) begin awaddr = a; awvalid = 1'b1; end
            if (w_pend && cyc >= w_dly) begin wdata = d; wstrb = s; wvalid = 1'b1; end
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            if (aw_fire) begin awvalid = 1'b0; aw_pend = 0; end
            if (w_fire) begin wvalid = 1'b0; w_pend = 0; end
            if ((aw_pend || w_pend) && bvalid) early = 1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_handshakes", {30'd0, aw_pend, w_pend}, 32'd0);
        check("wr_bvalid_early", {31'd0, early}, 32'd0);
        lat = 0;
        while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
        resp = bresp;
        for (int i = 0; i < hold; i++) begin
            if (!bvalid || bresp !== resp || awready || wready) unstable = 1;
            @(negedge clk);
        end
        check("wr_b_hold", {31'd0, unstable}, 32'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Full read transaction; lat counts edges from the AR handshake to rvalid.
    task automatic axi_read(input logic [15:0] a, input int hold,
                            output logic [31:0] d, output logic [1:0] resp, output int lat);
        int cyc;
        bit unstable;
        cyc = 0; unstable = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        while (!arready && cyc < 50) begin @(negedge clk); cyc++; end
        check("rd_ar_accept", {31'd0, (cyc < 50)}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        d = rdata;
        resp = rresp;
        for (int i = 0; i < hold; i++) begin
            if (!rvalid || rdata !== d || rresp !== resp || arready) unstable = 1;
            @(negedge clk);
        end
        check("rd_r_hold", {31'd0, unstable}, 32'd0);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    typedef struct {
        bit          is_rd;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_commit;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    // Watchdog so the run always terminates.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [31:0] rd;
        logic [1:0]  rs, b_rs;
        int          lat, c0;
        bit          got_b;

        vecs[0]  = '{0, 16'h0014, 32'h0000_0005, 4'hF, 2'b00, 32'h0, 1};
        vecs[1]  = '{1, 16'h0014, 32'h0, 4'h0, 2'b00, 32'h0000_0005, 0};
        vecs[2]  = '{0, 16'h2000, 32'hAABB_CCDD, 4'hF, 2'b00, 32'h0, 0};
        vecs[3]  = '{0, 16'h2000, 32'h1122_3344, 4'h5, 2'b00, 32'h0, 0};
        vecs[4]  = '{1, 16'h2000, 32'h0, 4'h0, 2'b00, 32'hAA22_CC44, 0};
        vecs[5]  = '{0, 16'h1400, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0, 0};
        vecs[6]  = '{1, 16'h1400, 32'h0, 4'h0, 2'b10, 32'h0, 0};
        vecs[7]  = '{0, 16'h0017, 32'h1234_5678, 4'h3, 2'b00, 32'h0, 1};
        vecs[8]  = '{1, 16'h0015, 32'h0, 4'h0, 2'b00, 32'h0000_5678, 0};
        vecs[9]  = '{0, 16'h0014, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0, 0};
        vecs[10] = '{1, 16'h0014, 32'h0, 4'h0, 2'b00, 32'h0000_5678, 0};
        vecs[11] = '{0, 16'h201C, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0, 0};
        vecs[12] = '{1, 16'h201C, 32'h0, 4'h0, 2'b00, 32'hCAFE_F00D, 0};
        vecs[13] = '{0, 16'h12BC, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h0, 1};
        vecs[14] = '{1, 16'h12BC, 32'h0, 4'h0, 2'b00, 32'h0BAD_F00D, 0};
        vecs[15] = '{0, 16'h12C0, 32'h1212_1212, 4'hF, 2'b10, 32'h0, 0};
        vecs[16] = '{1, 16'h12C0, 32'h0, 4'h0, 2'b10, 32'h0, 0};
        vecs[17] = '{0, 16'h2020, 32'h3434_3434, 4'hF, 2'b10, 32'h0, 0};
        vecs[18] = '{1, 16'h2020, 32'h0, 4'h0, 2'b10, 32'h0, 0};
        vecs[19] = '{1, 16'h1FFC, 32'h0, 4'h0, 2'b10, 32'h0, 0};

        rstn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_vram", {27'd0, vram_en, vram_we}, 32'd0);
        check("rst_pal_zero", {31'd0, (pal_out != '0)}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_states", {28'd0, w_state_dbg, r_state_dbg}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_rd) begin
                exp_q.push_back(vecs[i].exp_rdata);
                axi_read(vecs[i].addr, 0, rd, rs, lat);
                check($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
                check($sformatf("v%0d_rresp", i), {30'd0, rs}, {30'd0, vecs[i].exp_resp});
                check($sformatf("v%0d_rlat", i), lat, 32'd3);
            end else begin
                c0 = commit_cnt;
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, rs, lat);
                check($sformatf("v%0d_bresp", i), {30'd0, rs}, {30'd0, vecs[i].exp_resp});
                check($sformatf("v%0d_blat", i), lat, 32'd1);
                check($sformatf("v%0d_commits", i), commit_cnt - c0, vecs[i].exp_commit);
                if (vecs[i].exp_commit == 1) begin
                    check($sformatf("v%0d_we", i), {28'd0, last_we}, {28'd0, vecs[i].strb});
                    check($sformatf("v%0d_waddr", i), {21'd0, last_waddr}, {21'd0, vecs[i].addr[12:2]});
                end
            end
        end
        check("pal0", pal_out[31:0], 32'hAA22_CC44);
        check("pal7", pal_out[255:224], 32'hCAFE_F00D);
        check("pal_mid_zero", {31'd0, (pal_out[223:32] != '0)}, 32'd0);

        // AW three cycles before W, then W three cycles before AW.
        c0 = commit_cnt;
        axi_write(16'h0020, 32'h1111_0000, 4'hF, 0, 3, 0, rs, lat);
        check("aw_first_bresp", {30'd0, rs}, 32'd0);
        check("aw_first_commits", commit_cnt - c0, 32'd1);
        c0 = commit_cnt;
        axi_write(16'h0024, 32'h2222_0000, 4'hF, 3, 0, 0, rs, lat);
        check("w_first_bresp", {30'd0, rs}, 32'd0);
        check("w_first_commits", commit_cnt - c0, 32'd1);
        axi_read(16'h0020, 0, rd, rs, lat);
        check("aw_first_rdata", rd, 32'h1111_0000);
        axi_read(16'h0024, 0, rd, rs, lat);
        check("w_first_rdata", rd, 32'h2222_0000);

        // Back-pressure on B and R for five cycles.
        axi_write(16'h0050, 32'h1357_2468, 4'hF, 0, 0, 5, rs, lat);
        check("bp_bresp", {30'd0, rs}, 32'd0);
        axi_read(16'h0050, 5, rd, rs, lat);
        check("bp_rdata", rd, 32'h1357_2468);
        check("bp_rresp", {30'd0, rs}, 32'd0);

        // Read issue colliding with a VRAM write to the same word.
        axi_write(16'h0030, 32'hDEAD_0000, 4'hF, 0, 0, 0, rs, lat);
        @(negedge clk);
        awaddr = 16'h0030; awvalid = 1'b1; wdata = 32'h5A5A_1234; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 16'h0030; arvalid = 1'b1; bready = 1'b1;
        check("coll_readies", {29'd0, awready, wready, arready}, 32'd7);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_vram_we", {28'd0, vram_we}, 32'hF);
        check("coll_vram_addr", {21'd0, vram_addr}, 32'd12);
        check("coll_r_state", {30'd0, r_state_dbg}, 32'd1);
        lat = 0; got_b = 0; b_rs = 2'b11;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bvalid) begin got_b = 1; b_rs = bresp; end
        end
        check("coll_rlat", lat, 32'd4);
        check("coll_rdata", rdata, 32'h5A5A_1234);
        check("coll_rresp", {30'd0, rresp}, 32'd0);
        check("coll_bvalid_seen", {31'd0, got_b}, 32'd1);
        check("coll_bresp", {30'd0, b_rs}, 32'd0);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;

        // Reset asserted while the write is in W_EXEC.
        @(negedge clk);
        check("mid_rst_ready", {30'd0, awready, wready}, 32'd3);
        awaddr = 16'h0040; awvalid = 1'b1; wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("mid_rst_exec_en", {31'd0, vram_en}, 32'd1);
        c0 = commit_cnt;
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_vram", {27'd0, vram_en, vram_we}, 32'd0);
        check("mid_rst_b", {29'd0, bvalid, awready, wready}, 32'd0);
        check("mid_rst_state", {30'd0, w_state_dbg}, 32'd0);
        check("mid_rst_pal", {31'd0, (pal_out != '0)}, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_no_commit", commit_cnt - c0, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        axi_write(16'h0040, 32'h0000_0088, 4'hF, 0, 0, 0, rs, lat);
        check("post_rst_bresp", {30'd0, rs}, 32'd0);
        check("post_rst_blat", lat, 32'd1);
        axi_read(16'h0040, 0, rd, rs, lat);
        check("post_rst_rdata", rd, 32'h0000_0088);
        check("post_rst_rlat", lat, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
